// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gate_pkg
//  Description : Shared definitions for the two-input gate sweep checker.
//                Holds the sweep FSM state encoding and the golden 4-bit truth
//                tables for the common gates.
//                Truth-table bit i is the expected y for {a,b} = i.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gate_state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage : gate_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : 8-bit loadable down-counter that times the settle window.
//                It counts down to zero and then holds at zero until the next
//                load.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset (count -> 0)
//                load       - load load_value on the next edge
//                load_value - value to load
//                zero       - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign zero = (r_count == 8'd0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_ctrl
//  Description : Drives the four {a,b} combinations onto a two-input gate.
//                Each vector is held SETTLE_CYCLES cycles before y is sampled.
//                The captured truth table is then compared against the golden
//                one latched at start.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                start    - sweep request, honoured only in IDLE
//                expected - golden truth table, latched on accepted start
//                dut_a    - gate input a (MSB of the vector index)
//                dut_b    - gate input b (LSB of the vector index)
//                dut_y    - gate output, combinational in dut_a/dut_b
//                busy     - sweep in progress, through the DONE cycle
//                done     - one-cycle pulse in DONE
//                pass     - result matched expected (valid after done)
//                result   - captured y per vector
//                mismatch - result XOR latched expected
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] mismatch
);

    // The timer runs from SETTLE_CYCLES-1 down to 0, so SETTLE lasts exactly
    // SETTLE_CYCLES cycles.
    localparam logic [7:0] c_load_value = 8'(SETTLE_CYCLES - 1);

    gate_state_e r_state;
    gate_state_e w_state_next;
    logic [1:0]  r_vec;
    logic [1:0]  r_ab;
    logic [3:0]  r_expected;
    logic [3:0]  r_result;
    logic [3:0]  r_mismatch;
    logic        r_pass;
    logic        w_load;
    logic        w_zero;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (c_load_value),
        .zero       (w_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SETTLE;
                    w_load       = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_vec == 2'd3) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETTLE;
                    w_load       = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vec      <= 2'd0;
            r_ab       <= 2'd0;
            r_expected <= 4'd0;
            r_result   <= 4'd0;
            r_mismatch <= 4'd0;
            r_pass     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_expected <= expected;
                        r_result   <= 4'd0;
                        r_mismatch <= 4'd0;
                        r_pass     <= 1'b0;
                        r_vec      <= 2'd0;
                        r_ab       <= 2'd0;
                    end
                end
                ST_SAMPLE: begin
                    r_result[r_vec] <= dut_y;
                    // The last vector stays applied after the sweep ends.
                    if (r_vec != 2'd3) begin
                        r_vec <= r_vec + 2'd1;
                        r_ab  <= r_vec + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_mismatch <= r_result ^ r_expected;
                    r_pass     <= (r_result == r_expected);
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_a    = r_ab[1];
    assign dut_b    = r_ab[0];
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign pass     = r_pass;
    assign result   = r_result;
    assign mismatch = r_mismatch;

endmodule : gate_sweep_ctrl
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_sweep_ctrl
//  Description : Self-checking bench for gate_sweep_ctrl. Two instances are
//                used, one with SETTLE_CYCLES=2 and one with SETTLE_CYCLES=1.
//                Each instance drives a behavioural gate model given as a
//                truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;
    import gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 0: SETTLE_CYCLES=2, instance 1: SETTLE_CYCLES=1
    logic       start0, start1;
    logic [3:0] exp0, exp1, model0, model1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] res0, mis0, res1, mis1;

    assign y0 = model0[{a0, b0}];
    assign y1 = model1[{a1, b1}];

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0), .busy(busy0), .done(done0),
        .pass(pass0), .result(res0), .mismatch(mis0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .result(res1), .mismatch(mis1)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [1:0] ab;
        logic [3:0] result;
        logic [3:0] mismatch;
    } obs_t;

    typedef struct {
        int         sel;
        logic [3:0] model;
        logic [3:0] exp_tt;
        int         toggle_at;
        int         done_cyc;
        logic [3:0] result;
        logic [3:0] mismatch;
        logic       pass;
    } vec_t;

    typedef struct {
        int         done_cyc;
        logic [3:0] result;
        logic [3:0] mismatch;
        logic       pass;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic obs_t snap(input int sel);
        obs_t o;
        if (sel == 0) o = '{busy0, done0, pass0, {a0, b0}, res0, mis0};
        else          o = '{busy1, done1, pass1, {a1, b1}, res1, mis1};
        return o;
    endfunction

    function automatic int settle_of(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    task automatic set_exp(input int sel, input logic [3:0] v);
        if (sel == 0) exp0 = v; else exp1 = v;
    endtask

    task automatic set_model(input int sel, input logic [3:0] v);
        if (sel == 0) model0 = v; else model1 = v;
    endtask

    task automatic check_zero(input string tag, input int sel);
        obs_t o;
        o = snap(sel);
        check({tag, "_busy"}, 32'(o.busy), 0);
        check({tag, "_done"}, 32'(o.done), 0);
        check({tag, "_pass"}, 32'(o.pass), 0);
        check({tag, "_ab"}, 32'(o.ab), 0);
        check({tag, "_result"}, 32'(o.result), 0);
        check({tag, "_mismatch"}, 32'(o.mismatch), 0);
    endtask

    // One complete sweep. Expectations are queued at start and popped once
    // the DUT signals done.
    task automatic run_sweep(input vec_t v);
        obs_t o;
        sb_t  e;
        int   c;
        int   s;
        int   ab_err;
        bit   seen;
        s = settle_of(v.sel);
        set_model(v.sel, v.model);
        set_exp(v.sel, v.exp_tt);
        set_start(v.sel, 1'b1);
        sb_q.push_back('{v.done_cyc, v.result, v.mismatch, v.pass});
        @(negedge clk);
        set_start(v.sel, 1'b0);
        c = 1;
        o = snap(v.sel);
        check("busy_after_start", 32'(o.busy), 1);
        ab_err = 0;
        seen   = 0;
        while (c <= 100) begin
            o = snap(v.sel);
            if (v.toggle_at == c) set_exp(v.sel, 4'b0000);
            if (o.done) begin
                seen = 1;
                break;
            end
            if (o.ab != 2'((c - 1) / (s + 1))) ab_err++;
            @(negedge clk);
            c++;
        end
        e = sb_q.pop_front();
        check("done_seen", 32'(seen), 1);
        check("done_cycle", 32'(c), 32'(e.done_cyc));
        check("busy_in_done", 32'(o.busy), 1);
        check("ab_sequence_errors", 32'(ab_err), 0);
        check("ab_in_done", 32'(o.ab), 3);
        @(negedge clk);
        o = snap(v.sel);
        check("busy_after_done", 32'(o.busy), 0);
        check("done_pulse_width", 32'(o.done), 0);
        check("result", 32'(o.result), 32'(e.result));
        check("mismatch", 32'(o.mismatch), 32'(e.mismatch));
        check("pass", 32'(o.pass), 32'(e.pass));
        check("ab_hold_after", 32'(o.ab), 3);
    endtask

    initial begin
        obs_t o;
        int   n_done;
        int   first_done;
        int   second_done;
        int   k;

        tbl[0] = '{0, TT_OR,   TT_OR,   0, 13, 4'b1110, 4'b0000, 1'b1};
        tbl[1] = '{0, TT_XOR,  TT_OR,   0, 13, 4'b0110, 4'b1000, 1'b0};
        tbl[2] = '{1, TT_AND,  TT_AND,  0,  9, 4'b1000, 4'b0000, 1'b1};
        tbl[3] = '{0, TT_OR,   TT_OR,   5, 13, 4'b1110, 4'b0000, 1'b1};
        tbl[4] = '{1, TT_XOR,  TT_XNOR, 0,  9, 4'b0110, 4'b1111, 1'b0};
        tbl[5] = '{0, TT_NOR,  TT_NAND, 0, 13, 4'b0001, 4'b0110, 1'b0};

        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        exp0   = 4'd0;
        exp1   = 4'd0;
        model0 = TT_OR;
        model1 = TT_AND;
        repeat (3) @(negedge clk);
        check_zero("reset_s2", 0);
        check_zero("reset_s1", 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i]);
            @(negedge clk);
        end

        // Start held high for 30 cycles: DONE ignores start, so the second
        // sweep begins from the IDLE cycle that follows DONE.
        model0      = TT_OR;
        exp0        = TT_OR;
        start0      = 1'b1;
        n_done      = 0;
        first_done  = 0;
        second_done = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            o = snap(0);
            if (o.done) begin
                n_done++;
                if (n_done == 1) first_done = c;
                if (n_done == 2) second_done = c;
            end
            if (c == 14) check("held_idle_after_done", 32'(o.busy), 0);
        end
        start0 = 1'b0;
        check("held_done_count", 32'(n_done), 2);
        check("held_first_done", 32'(first_done), 13);
        check("held_done_spacing", 32'(second_done - first_done), 14);
        k = 0;
        while (busy0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("held_drain_timeout", 32'(busy0), 0);
        @(negedge clk);

        // Reset during SETTLE of vector 2 (cycles 7 and 8 with S=2).
        model0 = TT_OR;
        exp0   = TT_OR;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        o = snap(0);
        check("midreset_ab_before", 32'(o.ab), 2);
        check("midreset_result_before", 32'(o.result), 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset", 0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 || busy0) n_done++;
        end
        check("midreset_no_activity", 32'(n_done), 0);
        run_sweep(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gate_sweep_ctrl
`default_nettype wire
